// File: rtl/vc_credit_onehot_tracker.sv
`default_nettype none
// ============================================================================
// Module   : vc_credit_onehot_tracker
// Purpose  : Per-output-port credit tracker for a VC-based mesh router.
//            Decodes binary VC ids from the send and credit-return paths into
//            one-hot form, keeps one credit counter per VC, and presents
//            one-hot masks of VCs with free downstream slots and of VCs whose
//            downstream buffer is fully drained.
// Config   : VC_CREDIT_ERR_CHK_EN - when defined, illegal sends/credits and
//            out-of-range ids are dropped and the sticky error flags operate.
//            When undefined, counters update unconditionally (and may wrap)
//            and both error outputs are tied to 0.
// Ports    : clk              - clock, rising edge
//            reset            - synchronous, active-high
//            send_en          - flit sent this cycle, consumes one credit
//            send_vc_bin      - binary VC id of the sent flit
//            credit_in_en     - one credit returned this cycle
//            credit_in_vc_bin - binary VC id of the returned credit
//            send_vc_onehot   - registered one-hot of the last accepted send
//            vc_avail_onehot  - bit i set when credit[i] > 0
//            vc_empty_onehot  - bit i set when credit[i] == B
//            underflow_err    - sticky, send with zero credits
//            overflow_err     - sticky, credit at B or out-of-range id
// Revision : 1.0 - initial release
// ============================================================================
module vc_credit_onehot_tracker #(
   parameter int V           = 4,
   parameter int VC_ID_WIDTH = 2,
   parameter int B           = 4,
   parameter int CNT_W       = $clog2(B + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   send_en,
   input  logic [VC_ID_WIDTH-1:0] send_vc_bin,
   input  logic                   credit_in_en,
   input  logic [VC_ID_WIDTH-1:0] credit_in_vc_bin,
   output logic [V-1:0]           send_vc_onehot,
   output logic [V-1:0]           vc_avail_onehot,
   output logic [V-1:0]           vc_empty_onehot,
   output logic                   underflow_err,
   output logic                   overflow_err
);

   localparam logic [CNT_W-1:0] c_B    = CNT_W'(B);
   localparam logic [CNT_W-1:0] c_ZERO = '0;

   logic [V-1:0]            w_send_hit;
   logic [V-1:0]            w_cred_hit;
   logic [V-1:0]            w_send_ok;
   logic [V-1:0]            w_cred_ok;
   logic [V-1:0][CNT_W-1:0] r_credit;
   logic [V-1:0]            r_send_oh;

   // Binary-to-one-hot decode, qualified by the enables. Ids >= V match no
   // bit and therefore decode to all-zero.
   always_comb begin
      w_send_hit = '0;
      w_cred_hit = '0;
      for (int i = 0; i < V; i++) begin
         w_send_hit[i] = send_en      && (send_vc_bin      == VC_ID_WIDTH'(i));
         w_cred_hit[i] = credit_in_en && (credit_in_vc_bin == VC_ID_WIDTH'(i));
      end
   end

   // Acceptance per VC. A same-VC send/credit pair is always legal because
   // it nets to zero, so each side of the pair legitimises the other even at
   // the counter limits.
   generate
      for (genvar gi = 0; gi < V; gi++) begin : g_vc
`ifdef VC_CREDIT_ERR_CHK_EN
         assign w_send_ok[gi] = w_send_hit[gi] &
                                ((r_credit[gi] != c_ZERO) | w_cred_hit[gi]);
         assign w_cred_ok[gi] = w_cred_hit[gi] &
                                ((r_credit[gi] != c_B) | w_send_hit[gi]);
`else
         assign w_send_ok[gi] = w_send_hit[gi];
         assign w_cred_ok[gi] = w_cred_hit[gi];
`endif
         // Status masks come straight from the counter registers.
         assign vc_avail_onehot[gi] = (r_credit[gi] != c_ZERO);
         assign vc_empty_onehot[gi] = (r_credit[gi] == c_B);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < V; i++) begin
            r_credit[i] <= c_B;
         end
         r_send_oh <= '0;
      end else begin
         for (int i = 0; i < V; i++) begin
            if (w_send_ok[i] && !w_cred_ok[i]) begin
               r_credit[i] <= r_credit[i] - CNT_W'(1);
            end else if (w_cred_ok[i] && !w_send_ok[i]) begin
               r_credit[i] <= r_credit[i] + CNT_W'(1);
            end
         end
         r_send_oh <= w_send_ok;
      end
   end

   assign send_vc_onehot = r_send_oh;

`ifdef VC_CREDIT_ERR_CHK_EN
   logic r_underflow;
   logic r_overflow;
   logic w_underflow_evt;
   logic w_overflow_evt;

   // An enabled request that hits no VC carries an out-of-range id.
   assign w_underflow_evt = |(w_send_hit & ~w_send_ok);
   assign w_overflow_evt  = (|(w_cred_hit & ~w_cred_ok)) ||
                            (send_en      && (w_send_hit == '0)) ||
                            (credit_in_en && (w_cred_hit == '0));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_underflow <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_underflow_evt) begin
            r_underflow <= 1'b1;
         end
         if (w_overflow_evt) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign underflow_err = r_underflow;
   assign overflow_err  = r_overflow;
`else
   assign underflow_err = 1'b0;
   assign overflow_err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vc_credit_onehot_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_vc_credit_onehot_tracker
// Purpose  : Self-checking bench for vc_credit_onehot_tracker (V=4, B=4,
//            3-bit ids so out-of-range ids can be driven). Directed steps
//            followed by random traffic, compared against a credit-count
//            model. Follows VC_CREDIT_ERR_CHK_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vc_credit_onehot_tracker;

   localparam int V     = 4;
   localparam int IDW   = 3;
   localparam int B     = 4;
   localparam int CNT_W = $clog2(B + 1);
   localparam int MODV  = 1 << CNT_W;
`ifdef VC_CREDIT_ERR_CHK_EN
   localparam bit ERRCHK = 1'b1;
`else
   localparam bit ERRCHK = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset;
   logic           send_en;
   logic [IDW-1:0] send_vc_bin;
   logic           credit_in_en;
   logic [IDW-1:0] credit_in_vc_bin;
   logic [V-1:0]   send_vc_onehot;
   logic [V-1:0]   vc_avail_onehot;
   logic [V-1:0]   vc_empty_onehot;
   logic           underflow_err;
   logic           overflow_err;

   vc_credit_onehot_tracker #(
      .V(V), .VC_ID_WIDTH(IDW), .B(B), .CNT_W(CNT_W)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .send_en          (send_en),
      .send_vc_bin      (send_vc_bin),
      .credit_in_en     (credit_in_en),
      .credit_in_vc_bin (credit_in_vc_bin),
      .send_vc_onehot   (send_vc_onehot),
      .vc_avail_onehot  (vc_avail_onehot),
      .vc_empty_onehot  (vc_empty_onehot),
      .underflow_err    (underflow_err),
      .overflow_err     (overflow_err)
   );

   always #5 clk = ~clk;

   // Reference state: plain credit counts and flags.
   int cred [V];
   int m_send_oh;
   bit m_uf;
   bit m_of;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model(input bit rst, input bit se, input int sv, input bit ce, input int cv);
      if (rst) begin
         for (int i = 0; i < V; i++) cred[i] = B;
         m_send_oh = 0;
         m_uf = 0;
         m_of = 0;
         return;
      end
      m_send_oh = 0;
      for (int i = 0; i < V; i++) begin
         bit sh = se && (sv == i);
         bit ch = ce && (cv == i);
         if (sh && ch) begin
            m_send_oh |= (1 << i);
         end else if (sh) begin
            if (!ERRCHK) begin
               cred[i] = (cred[i] + MODV - 1) % MODV;
               m_send_oh |= (1 << i);
            end else if (cred[i] > 0) begin
               cred[i]--;
               m_send_oh |= (1 << i);
            end else begin
               m_uf = 1;
            end
         end else if (ch) begin
            if (!ERRCHK) cred[i] = (cred[i] + 1) % MODV;
            else if (cred[i] < B) cred[i]++;
            else m_of = 1;
         end
      end
      if (ERRCHK && ((se && sv >= V) || (ce && cv >= V))) m_of = 1;
   endtask

   task automatic step(input bit rst, input bit se, input int sv, input bit ce, input int cv);
      int avail;
      int empty;
      @(negedge clk);
      reset            = rst;
      send_en          = se;
      send_vc_bin      = IDW'(sv);
      credit_in_en     = ce;
      credit_in_vc_bin = IDW'(cv);
      @(posedge clk);
      #1;
      model(rst, se, sv, ce, cv);
      avail = 0;
      empty = 0;
      for (int i = 0; i < V; i++) begin
         if (cred[i] > 0) avail |= (1 << i);
         if (cred[i] == B) empty |= (1 << i);
      end
      chk("avail",     32'(vc_avail_onehot), 32'(avail));
      chk("empty",     32'(vc_empty_onehot), 32'(empty));
      chk("send_oh",   32'(send_vc_onehot),  32'(m_send_oh));
      chk("underflow", 32'(underflow_err),   32'(m_uf));
      chk("overflow",  32'(overflow_err),    32'(m_of));
   endtask

   initial begin
      reset = 1'b1;
      send_en = 1'b0;
      send_vc_bin = '0;
      credit_in_en = 1'b0;
      credit_in_vc_bin = '0;

      // Reset then idle.
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      // Four back-to-back sends to VC2, then a fifth at zero credit.
      for (int k = 0; k < 4; k++) step(0, 1, 2, 0, 0);
      step(0, 1, 2, 0, 0);
      step(1, 0, 0, 0, 0);
      // Drain VC1 to zero, then paired send+credit at zero.
      for (int k = 0; k < 4; k++) step(0, 1, 1, 0, 0);
      step(0, 1, 1, 1, 1);
      step(0, 0, 0, 0, 0);
      // Paired send+credit at B on VC0.
      step(0, 1, 0, 1, 0);
      // Independent send and credit on different VCs.
      step(0, 1, 3, 1, 1);
      // Credit return to VC3 at B after reset, then out-of-range id.
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 3);
      step(1, 0, 0, 0, 0);
      step(0, 1, 5, 0, 0);
      step(0, 0, 0, 1, 7);
      // Reset mid-traffic with VC0 at credit 1.
      step(1, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      // Five sends to VC0 (wraps when range guards are absent).
      for (int k = 0; k < 5; k++) step(0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);

      // Random traffic with occasional resets and out-of-range ids.
      for (int k = 0; k < 600; k++) begin
         bit rr = ($urandom_range(0, 63) == 0);
         bit se = $urandom_range(0, 1) == 1;
         bit ce = $urandom_range(0, 1) == 1;
         int sv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
         int cv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
         step(rr, se, sv, ce, cv);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
